// File: rtl/iec_fast_pkg.sv
// Shared definitions for the host-side fast-serial transceiver.
//   tx_state_e : TX FSM states (idle, FCLK low phase, FCLK high phase)
//   BITS       : bits per fast-serial byte
package iec_fast_pkg;

  localparam int unsigned BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } tx_state_e;

endpackage

// File: rtl/iec_fast_sync.sv
// Two-flop synchroniser with rising-edge detect for one asynchronous bus line.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   async_i    : raw bus level
//   level_o    : synchronised level
//   rise_o     : 1-clk pulse on a synchronised 0->1 transition
module iec_fast_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  // [0],[1] synchronise, [2] holds the previous synced level for edge detect.
  logic [2:0] ff_q;

  // Reset to the released (high) bus level so a line already high out of
  // reset does not look like a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff_q <= 3'b111;
    end else begin
      ff_q <= {ff_q[1:0], async_i};
    end
  end

  always_comb begin
    level_o = ff_q[1];
    rise_o  = ff_q[1] & ~ff_q[2];
  end

endmodule

// File: rtl/iec_fast_ser_host.sv
// Host-side fast-serial (burst) transceiver on the IEC FCLK/DATA lines.
// TX clocks bytes out MSB-first (data changes while FCLK is low, drive samples on
// the rising edge); RX shifts in bytes clocked by the drive. dir selects direction.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   ce                    : timing tick enable
//   dir                   : 1 = host transmits, 0 = host receives
//   tx_data/valid/ready   : byte send handshake; tx_done pulses after bit 8
//   rx_data/valid/ack     : received byte, held until acknowledged
//   rx_overrun            : sticky, a byte completed while rx_valid was set
//   iec_fclk_i/iec_data_i : asynchronous bus levels
//   iec_fclk_o/iec_data_o : open-collector drives, 1 = released
module iec_fast_ser_host
  import iec_fast_pkg::*;
#(
  parameter int unsigned HALF     = 4,
  parameter int unsigned IDLE_TMO = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       dir,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  input  logic       iec_fclk_i,
  input  logic       iec_data_i,
  output logic       iec_fclk_o,
  output logic       iec_data_o
);

  localparam int unsigned HalfW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned TmoW  = (IDLE_TMO > 1) ? $clog2(IDLE_TMO) : 1;
  localparam logic [HalfW-1:0] HalfLast = HalfW'(HALF - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(IDLE_TMO - 1);
  localparam logic [2:0]       BitLast  = 3'(BITS - 1);

  // ---------------------------------------------------------------- sync
  logic fclk_s, fclk_rise, data_s, data_rise_unused;

  iec_fast_sync u_sync_fclk (
    .clk     (clk),
    .reset   (reset),
    .async_i (iec_fclk_i),
    .level_o (fclk_s),
    .rise_o  (fclk_rise)
  );

  iec_fast_sync u_sync_data (
    .clk     (clk),
    .reset   (reset),
    .async_i (iec_data_i),
    .level_o (data_s),
    .rise_o  (data_rise_unused)
  );

  // ------------------------------------------------------------------ TX
  tx_state_e        tx_state_q, tx_state_d;
  logic [7:0]       tx_sr_q, tx_sr_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [HalfW-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_done_q, tx_done_d;
  logic             half_end;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_sr_d    = tx_sr_q;
    tx_bit_d   = tx_bit_q;
    tx_cnt_d   = tx_cnt_q;
    tx_done_d  = 1'b0;
    tx_ready   = 1'b0;
    iec_fclk_o = 1'b1;
    iec_data_o = 1'b1;
    half_end   = ce && (tx_cnt_q == HalfLast);

    unique case (tx_state_q)
      StIdle: begin
        tx_ready = dir;
        tx_cnt_d = '0;
        if (tx_valid && dir) begin
          tx_sr_d    = tx_data;
          tx_bit_d   = '0;
          tx_state_d = StLow;
        end
      end
      StLow: begin
        iec_fclk_o = 1'b0;
        iec_data_o = tx_sr_q[7];
        if (!dir) begin
          tx_state_d = StIdle;
          tx_cnt_d   = '0;
        end else if (half_end) begin
          tx_cnt_d   = '0;
          tx_state_d = StHigh;
        end else if (ce) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StHigh: begin
        // DATA held through the high phase; the drive samples on the rising edge.
        iec_data_o = tx_sr_q[7];
        if (!dir) begin
          tx_state_d = StIdle;
          tx_cnt_d   = '0;
        end else if (half_end) begin
          tx_cnt_d = '0;
          tx_sr_d  = {tx_sr_q[6:0], 1'b0};
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == BitLast) begin
            tx_state_d = StIdle;
            tx_done_d  = 1'b1;
          end else begin
            tx_state_d = StLow;
          end
        end else if (ce) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_sr_q    <= '0;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sr_q    <= tx_sr_d;
      tx_bit_q   <= tx_bit_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_done = tx_done_q;

  // ------------------------------------------------------------------ RX
  logic            dir_q;
  logic [6:0]      rx_sr_q, rx_sr_d;
  logic [2:0]      rx_cnt_q, rx_cnt_d;
  logic [TmoW-1:0] rx_tmo_q, rx_tmo_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            rx_ovr_q, rx_ovr_d;
  logic            rx_complete;

  always_comb begin
    rx_sr_d     = rx_sr_q;
    rx_cnt_d    = rx_cnt_q;
    rx_tmo_d    = rx_tmo_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ovr_d    = rx_ovr_q;
    rx_complete = 1'b0;

    if (dir != dir_q) begin
      // Any direction change abandons a partial byte and the overrun history.
      rx_cnt_d = '0;
      rx_tmo_d = '0;
      rx_ovr_d = 1'b0;
    end else if (!dir) begin
      if (fclk_rise) begin
        rx_sr_d  = {rx_sr_q[5:0], data_s};
        rx_tmo_d = '0;
        if (rx_cnt_q == BitLast) begin
          rx_cnt_d    = '0;
          rx_complete = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end else if (rx_cnt_q != '0 && fclk_s) begin
        // FCLK parked high mid-byte: the sender gave up, drop the stale bits.
        if (ce) begin
          if (rx_tmo_q == TmoLast) begin
            rx_cnt_d = '0;
            rx_tmo_d = '0;
          end else begin
            rx_tmo_d = rx_tmo_q + 1'b1;
          end
        end
      end else begin
        rx_tmo_d = '0;
      end
    end else begin
      rx_tmo_d = '0;
    end

    if (rx_complete) begin
      rx_data_d  = {rx_sr_q, data_s};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_ack) rx_ovr_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= 1'b0;
      rx_sr_q    <= '0;
      rx_cnt_q   <= '0;
      rx_tmo_q   <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      dir_q      <= dir;
      rx_sr_q    <= rx_sr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_tmo_q   <= rx_tmo_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_ovr_q;

endmodule

// File: tb/tb_iec_fast_ser_host.sv
module tb_iec_fast_ser_host;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic       dir = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ack = 1'b0;
  logic       fclk_i = 1'b1;
  logic       data_i = 1'b1;
  logic       tx_ready, tx_done, rx_valid, rx_overrun, fclk_o, data_o;
  logic [7:0] rx_data;

  iec_fast_ser_host #(.HALF(HALF), .IDLE_TMO(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .dir        (dir),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .iec_fclk_i (fclk_i),
    .iec_data_i (data_i),
    .iec_fclk_o (fclk_o),
    .iec_data_o (data_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the host-visible RX state.
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_rx(input string tag);
    check8({tag, "_rx_data"}, rx_data, m_data);
    check1({tag, "_rx_valid"}, rx_valid, m_valid);
    check1({tag, "_rx_overrun"}, rx_overrun, m_ovr);
  endtask

  task automatic set_dir(input logic v);
    if (v != dir) m_ovr = 1'b0;
    dir = v;
    tick(1);
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  // Sends one byte; abort_bits >= 0 drops dir after that many complete bits.
  task automatic tx_byte(input logic [7:0] b, input int abort_bits, input bit poke);
    logic seen;
    check1("tx_ready_pre", tx_ready, 1'b1);
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    for (int k = 0; k < 16 * HALF; k++) begin
      if (abort_bits >= 0 && k == abort_bits * 2 * HALF) begin
        dir = 1'b0;
        m_ovr = 1'b0;
        tick(1);
        check1("abort_fclk", fclk_o, 1'b1);
        check1("abort_data", data_o, 1'b1);
        seen = tx_done;
        for (int j = 0; j < 80; j++) begin
          tick(1);
          seen = seen | tx_done;
        end
        check1("abort_no_done", seen, 1'b0);
        return;
      end
      if (poke && k == 10) begin
        tx_valid = 1'b1;
        tx_data = ~b;
      end
      if (poke && k == 14) tx_valid = 1'b0;
      check1("tx_fclk", fclk_o, 1'((k / HALF) % 2));
      check1("tx_data", data_o, b[7 - (k / (2 * HALF))]);
      check1("tx_done_early", tx_done, 1'b0);
      check1("tx_busy", tx_ready, 1'b0);
      tick(1);
    end
    check1("tx_done", tx_done, 1'b1);
    check1("tx_end_fclk", fclk_o, 1'b1);
    check1("tx_end_data", data_o, 1'b1);
    check1("tx_ready_post", tx_ready, 1'b1);
    tick(1);
    check1("tx_done_pulse", tx_done, 1'b0);
  endtask

  // Clocks n bits MSB-first from b (starting at bit 7); full high phase each.
  task automatic rx_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      fclk_i = 1'b0;
      data_i = b[7 - i];
      tick(4);
      fclk_i = 1'b1;
      tick(4);
    end
  endtask

  // Clocks a whole byte; returns 3 clk after the 8th rising edge.
  task automatic rx_byte(input logic [7:0] b, input bit ack_end);
    rx_bits(b, 7);
    fclk_i = 1'b0;
    data_i = b[0];
    tick(4);
    fclk_i = 1'b1;
    tick(2);
    rx_ack = ack_end;
    tick(1);
    rx_ack = 1'b0;
    if (!dir) begin
      if (m_valid && !ack_end) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data = b;
    end else if (ack_end) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] b;
    bit         a;

    // Reset
    tick(3);
    check1("rst_fclk", fclk_o, 1'b1);
    check1("rst_data", data_o, 1'b1);
    check1("rst_ready", tx_ready, 1'b1);
    reset = 1'b0;
    tick(1);
    check1("rel_fclk", fclk_o, 1'b1);
    check1("rel_data", data_o, 1'b1);
    check1("rel_ready", tx_ready, 1'b1);
    check1("rel_done", tx_done, 1'b0);
    check_rx("rel");

    // TX: directed byte, then random bytes with busy pokes
    tx_byte(8'hA5, -1, 1'b0);
    for (int i = 0; i < 3; i++) tx_byte(8'($urandom), -1, 1'($urandom_range(0, 1)));

    // RX basic
    set_dir(1'b0);
    tick(4);
    rx_byte(8'h3C, 1'b0);
    check_rx("rx_3c");
    do_ack();
    check_rx("rx_3c_ack");

    // Overrun and same-clk ack
    rx_byte(8'h11, 1'b0);
    rx_byte(8'h22, 1'b0);
    check_rx("ovr_set");
    do_ack();
    set_dir(1'b1);
    set_dir(1'b0);
    check_rx("ovr_cleared");
    rx_byte(8'h11, 1'b0);
    rx_byte(8'h22, 1'b1);
    check_rx("ack_same_clk");
    do_ack();

    // Random RX traffic
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      rx_byte(b, a);
      check_rx("rx_rand");
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        check_rx("rx_rand_ack");
      end
    end
    do_ack();

    // Timeout drops stale partial bits
    rx_bits(8'($urandom), 3);
    tick(300);
    rx_byte(8'hF0, 1'b0);
    check_rx("tmo_f0");
    do_ack();

    // Direction toggle drops partial bits
    rx_bits(8'($urandom), 3);
    set_dir(1'b1);
    set_dir(1'b0);
    b = 8'($urandom);
    rx_byte(b, 1'b0);
    check_rx("toggle_partial");

    // RX ignores edges while transmitting
    set_dir(1'b1);
    rx_byte(8'($urandom), 1'b0);
    check_rx("dir1_ignore");

    // TX abort, then a clean byte
    tx_byte(8'hFF, 3, 1'b0);
    set_dir(1'b1);
    check1("abort_ready", tx_ready, 1'b1);
    tx_byte(8'h81, -1, 1'b0);

    // Reset in the middle of a TX byte
    tx_data = 8'($urandom);
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(1);
    check1("midtx_fclk_low", fclk_o, 1'b0);
    reset = 1'b1;
    tick(1);
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_data = 8'h00;
    check1("midrst_fclk", fclk_o, 1'b1);
    check1("midrst_data", data_o, 1'b1);
    check1("midrst_ready", tx_ready, 1'b1);
    check_rx("midrst");
    reset = 1'b0;
    tick(1);
    tx_byte(8'($urandom), -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
